// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT stage scheduler.
// Mode/state encodings and a width helper that never returns 0.
package ntt_pkg;

    typedef enum logic {
        NTT_FWD = 1'b0,
        NTT_INV = 1'b1
    } ntt_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } sched_state_e;

    // Counter width for a count of v values; a 1-value counter still needs one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Resettable fixed-depth shift register; matches issued read addresses
// to the PE result latency so they come back out as write addresses.
module ntt_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: this array is deliberately reset; a stale valid bit would otherwise
    // emit a phantom write right after a mid-run abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// Radix-2 NTT stage scheduler: issues LANES butterflies per cycle across all
// stages, forward (CT) or inverse (GS) ordering, with latency-matched writes.
module ntt_stage_sched
    import ntt_pkg::*;
#(
    parameter int N      = 256,
    parameter int LANES  = 2,
    parameter int PE_LAT = 4,
    localparam int LOGN  = $clog2(N),
    localparam int AW    = LOGN,
    localparam int TW    = LOGN - 1,
    localparam int SW    = $clog2(LOGN),
    localparam int CPS   = N / (2 * LANES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic                hold,
    output logic                rd_valid,
    output logic [LANES*AW-1:0] rd_addr_top,
    output logic [LANES*AW-1:0] rd_addr_bot,
    output logic [LANES*TW-1:0] tw_idx,
    output logic                wr_valid,
    output logic [LANES*AW-1:0] wr_addr_top,
    output logic [LANES*AW-1:0] wr_addr_bot,
    output logic [SW-1:0]       stage,
    output logic                last_stage,
    output logic                busy,
    output logic                done
);

    localparam int CW = clog2_min1(CPS);
    localparam int DW = clog2_min1(PE_LAT);
    localparam int DLW = 1 + 2 * LANES * AW;

    sched_state_e        state_q, state_d;
    ntt_mode_e           mode_q, mode_d;
    logic [CW-1:0]       c_q, c_d;
    logic [DW-1:0]       dcnt_q, dcnt_d;
    logic [SW-1:0]       stage_q, stage_d;
    logic                rd_valid_q, rd_valid_d;
    logic [LANES*AW-1:0] rd_top_q, rd_top_d, nxt_top;
    logic [LANES*AW-1:0] rd_bot_q, rd_bot_d, nxt_bot;
    logic [LANES*TW-1:0] tw_q, tw_d, nxt_tw;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Returns {top, bot, twiddle} for butterfly b of stage s.
    function automatic logic [2*AW+TW-1:0] bfly(input logic [AW-1:0] b,
                                                input logic [SW-1:0] s,
                                                input logic          inv);
        logic [AW-1:0] h, m, low, top, bot, tw_full;
        h       = inv ? (AW'(LOGN - 1) - AW'(s)) : AW'(s);
        m       = AW'(1) << h;
        low     = b & (m - AW'(1));
        top     = ((b >> h) << (h + AW'(1))) | low;
        bot     = top + m;
        tw_full = inv ? (low << s) : (low << (AW'(LOGN - 1) - h));
        return {top, bot, TW'(tw_full)};
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [2*AW+TW-1:0] res;
        assign res = bfly(AW'(int'(c_q) * LANES + k), stage_q, mode_q == NTT_INV);
        assign nxt_top[k*AW +: AW] = res[2*AW+TW-1 -: AW];
        assign nxt_bot[k*AW +: AW] = res[AW+TW-1 -: AW];
        assign nxt_tw[k*TW +: TW]  = res[TW-1:0];
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        c_d        = c_q;
        dcnt_d     = dcnt_q;
        stage_d    = stage_q;
        rd_valid_d = 1'b0;
        rd_top_d   = rd_top_q;
        rd_bot_d   = rd_bot_q;
        tw_d       = tw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    mode_d  = mode ? NTT_INV : NTT_FWD;
                    busy_d  = 1'b1;
                    c_d     = '0;
                    dcnt_d  = '0;
                    stage_d = '0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    rd_valid_d = 1'b1;
                    rd_top_d   = nxt_top;
                    rd_bot_d   = nxt_bot;
                    tw_d       = nxt_tw;
                    if (c_q == CW'(CPS - 1)) begin
                        c_d     = '0;
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                // Wait until the last write of this stage has left the PEs.
                if (dcnt_q == DW'(PE_LAT - 1)) begin
                    dcnt_d = '0;
                    if (stage_q == SW'(LOGN - 1)) begin
                        state_d = FIN;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = ISSUE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= NTT_FWD;
            c_q        <= '0;
            dcnt_q     <= '0;
            stage_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_top_q   <= '0;
            rd_bot_q   <= '0;
            tw_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            c_q        <= c_d;
            dcnt_q     <= dcnt_d;
            stage_q    <= stage_d;
            rd_valid_q <= rd_valid_d;
            rd_top_q   <= rd_top_d;
            rd_bot_q   <= rd_bot_d;
            tw_q       <= tw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    logic [DLW-1:0] dl_out;

    ntt_delay_line #(
        .WIDTH(DLW),
        .DEPTH(PE_LAT)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .din  ({rd_valid_q, rd_top_q, rd_bot_q}),
        .dout (dl_out)
    );

    assign wr_valid    = dl_out[DLW-1];
    assign wr_addr_top = dl_out[2*LANES*AW-1 -: LANES*AW];
    assign wr_addr_bot = dl_out[LANES*AW-1:0];

    assign rd_valid    = rd_valid_q;
    assign rd_addr_top = rd_top_q;
    assign rd_addr_bot = rd_bot_q;
    assign tw_idx      = tw_q;
    assign stage       = stage_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign last_stage  = busy_q && (stage_q == SW'(LOGN - 1));

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched: N=8, PE_LAT=3, with LANES=1 and LANES=4 instances.
// A butterfly-list model plus timing formulas is compared every cycle of a run.
module tb_ntt_stage_sched;

    localparam int N    = 8;
    localparam int LAT  = 3;
    localparam int LOGN = 3;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start1 = 1'b0, start4 = 1'b0, mode = 1'b0, hold = 1'b0;

    logic        rv1, wv1, last1, busy1, done1;
    logic [2:0]  top1, bot1, wtop1, wbot1;
    logic [1:0]  tw1, stg1;
    logic        rv4, wv4, last4, busy4, done4;
    logic [11:0] top4, bot4, wtop4, wbot4;
    logic [7:0]  tw4;
    logic [1:0]  stg4;

    ntt_stage_sched #(.N(N), .LANES(1), .PE_LAT(LAT)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .hold(hold),
        .rd_valid(rv1), .rd_addr_top(top1), .rd_addr_bot(bot1), .tw_idx(tw1),
        .wr_valid(wv1), .wr_addr_top(wtop1), .wr_addr_bot(wbot1),
        .stage(stg1), .last_stage(last1), .busy(busy1), .done(done1)
    );

    ntt_stage_sched #(.N(N), .LANES(4), .PE_LAT(LAT)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode), .hold(hold),
        .rd_valid(rv4), .rd_addr_top(top4), .rd_addr_bot(bot4), .tw_idx(tw4),
        .wr_valid(wv4), .wr_addr_top(wtop4), .wr_addr_bot(wbot4),
        .stage(stg4), .last_stage(last4), .busy(busy4), .done(done4)
    );

    typedef struct { int s; int top; int bot; int tw; } item_t;
    typedef struct { int t; int top; int bot; } wr_t;

    item_t q[$];
    wr_t   wq[$];
    int total = 0, bad = 0;
    int cyc = 0, t0 = 0, exp_done = 0, last_from = 0, cps = 4, active = 0;
    bit timing_chk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Butterfly b of stage s straight from the index definitions.
    function automatic item_t model_bf(input int b, input int s, input bit inv);
        item_t it;
        int h, m;
        h = inv ? (LOGN - 1 - s) : s;
        m = 2 ** h;
        it.s   = s;
        it.top = (b / m) * (2 * m) + (b % m);
        it.bot = it.top + m;
        it.tw  = inv ? (b % m) * (2 ** s) : (b % m) * (2 ** (LOGN - 1 - h));
        return it;
    endfunction

    function automatic bit in_win(input int rel);
        for (int s = 0; s < LOGN; s++) begin
            if (rel >= s * (cps + LAT) + 1 && rel <= s * (cps + LAT) + cps) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cmp(input int lanes, input logic rv, input logic [11:0] top, bot,
                       input logic [7:0] tw, input logic [1:0] stg, input logic wv,
                       input logic [11:0] wtop, wbot, input logic bsy, dn, lst);
        int rel;
        item_t e;
        wr_t w;
        bit exp_wv;
        rel = cyc - t0;
        if (timing_chk) check("rd_valid", int'(rv), int'(in_win(rel)));
        if (rv) begin
            for (int k = 0; k < lanes; k++) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_extra: got issue with empty model (cycle %0d)", rel);
                end else begin
                    e = q.pop_front();
                    check("rd_top", int'(top[k*AW +: AW]), e.top);
                    check("rd_bot", int'(bot[k*AW +: AW]), e.bot);
                    check("tw_idx", int'(tw[k*2 +: 2]), e.tw);
                    check("stage", int'(stg), e.s);
                    w.t = rel + LAT;
                    w.top = e.top;
                    w.bot = e.bot;
                    wq.push_back(w);
                end
            end
        end
        exp_wv = (wq.size() > 0) && (wq[0].t == rel);
        check("wr_valid", int'(wv), int'(exp_wv));
        if (exp_wv) begin
            for (int k = 0; k < lanes; k++) begin
                w = wq.pop_front();
                check("wr_top", int'(wtop[k*AW +: AW]), w.top);
                check("wr_bot", int'(wbot[k*AW +: AW]), w.bot);
            end
        end
        check("busy", int'(bsy), int'(rel >= 0 && rel < exp_done));
        check("done", int'(dn), int'(rel == exp_done));
        check("last_stage", int'(lst), int'(rel >= last_from && rel < exp_done));
        if (dn) check("left_over", q.size() + wq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (active == 1)
            cmp(1, rv1, 12'(top1), 12'(bot1), 8'(tw1), stg1, wv1, 12'(wtop1), 12'(wbot1),
                busy1, done1, last1);
        else if (active == 4)
            cmp(4, rv4, top4, bot4, tw4, stg4, wv4, wtop4, wbot4, busy4, done4, last4);
    end

    task automatic start_run(input int sel, input logic m, input int n_hold, input logic hold_too);
        q.delete();
        wq.delete();
        cps = N / (2 * sel);
        for (int s = 0; s < LOGN; s++)
            for (int b = 0; b < N / 2; b++) q.push_back(model_bf(b, s, m));
        @(negedge clk);
        t0         = cyc + 1;
        exp_done   = LOGN * (cps + LAT) + 1 + n_hold;
        last_from  = (LOGN - 1) * (cps + LAT) + n_hold;
        timing_chk = (n_hold == 0);
        if (sel == 1) start1 = 1'b1;
        else start4 = 1'b1;
        mode   = m;
        hold   = hold_too;
        active = sel;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        hold   = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    task automatic finish_run();
        wait_rel(exp_done + 1);
        active = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rv1", int'(rv1), 0);
        check("reset_busy1", int'(busy1), 0);
        check("reset_wv4", int'(wv4), 0);
        check("reset_top4", int'(top4), 0);
        reset = 1'b1;
        @(negedge clk);

        // Forward, one lane
        start_run(1, 1'b0, 0, 1'b0);
        wait_rel(1);
        check("t1_c1_top", int'(top1), 0);
        check("t1_c1_bot", int'(bot1), 1);
        wait_rel(9);
        check("t1_c9_top", int'(top1), 1);
        check("t1_c9_bot", int'(bot1), 3);
        check("t1_c9_tw", int'(tw1), 2);
        wait_rel(17);
        check("t1_c17_top", int'(top1), 2);
        check("t1_c17_bot", int'(bot1), 6);
        check("t1_c17_tw", int'(tw1), 2);
        wait_rel(22);
        check("t1_done22", int'(done1), 1);
        finish_run();

        // Inverse, with hold asserted alongside start
        start_run(1, 1'b1, 0, 1'b1);
        wait_rel(2);
        check("t2_c2_top", int'(top1), 1);
        check("t2_c2_bot", int'(bot1), 5);
        check("t2_c2_tw", int'(tw1), 1);
        wait_rel(5);
        check("t2_c5_wv", int'(wv1), 1);
        check("t2_c5_wtop", int'(wtop1), 1);
        check("t2_c5_wbot", int'(wbot1), 5);
        wait_rel(8);
        check("t2_c8_wv", int'(wv1), 0);
        wait_rel(18);
        check("t2_c18_top", int'(top1), 6);
        check("t2_c18_bot", int'(bot1), 7);
        check("t2_c18_tw", int'(tw1), 0);
        finish_run();

        // Two hold cycles inside stage 1
        start_run(1, 1'b0, 2, 1'b0);
        wait_rel(8);
        check("t3_c8_rv", int'(rv1), 1);
        check("t3_c8_bot", int'(bot1), 2);
        hold = 1'b1;
        wait_rel(9);
        check("t3_c9_rv", int'(rv1), 0);
        wait_rel(10);
        check("t3_c10_rv", int'(rv1), 0);
        check("t3_c10_bot", int'(bot1), 2);
        hold = 1'b0;
        wait_rel(11);
        check("t3_c11_rv", int'(rv1), 1);
        check("t3_c11_top", int'(top1), 1);
        check("t3_c11_bot", int'(bot1), 3);
        wait_rel(24);
        check("t3_done24", int'(done1), 1);
        finish_run();

        // Four lanes: one issue cycle per stage
        start_run(4, 1'b0, 0, 1'b0);
        wait_rel(1);
        check("t4_c1_top", int'(top4), 3344);
        check("t4_c1_bot", int'(bot4), 3929);
        check("t4_c1_tw", int'(tw4), 0);
        wait_rel(5);
        check("t4_c5_top", int'(top4), 2824);
        check("t4_c5_bot", int'(bot4), 3994);
        check("t4_c5_tw", int'(tw4), 136);
        wait_rel(13);
        check("t4_done13", int'(done4), 1);
        finish_run();

        // start while busy is ignored, then an abort by reset
        start_run(1, 1'b0, 0, 1'b0);
        wait_rel(4);
        start1 = 1'b1;
        mode   = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        mode   = 1'b0;
        wait_rel(10);
        active = 0;
        reset  = 1'b0;
        #1;
        check("t5_rst_rv", int'(rv1), 0);
        check("t5_rst_top", int'(top1), 0);
        check("t5_rst_busy", int'(busy1), 0);
        check("t5_rst_stage", int'(stg1), 0);
        check("t5_rst_wv", int'(wv1), 0);
        check("t5_rst_wbot", int'(wbot1), 0);
        @(negedge clk);
        check("t5_rst_last", int'(last1), 0);
        check("t5_rst_done", int'(done1), 0);
        reset = 1'b1;
        @(negedge clk);
        check("t5_idle_busy", int'(busy1), 0);
        start_run(1, 1'b1, 0, 1'b0);
        wait_rel(22);
        check("t5_done22", int'(done1), 1);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
